// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with bypass, core-ID register
// and a multi-cycle clear sequencer.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   core_id               static core identifier, read at CID_REG
//   rd_addr_a/rd_data_a   combinational read port A
//   rd_addr_b/rd_data_b   combinational read port B
//   wr_en/wr_addr/wr_data write request, accepted when wr_en && wr_ready
//   wr_ready              low while the clear sequence runs
//   clr_req               pulse that starts the clear sequence
//   busy                  clear sequence in progress
module regfile_param #(
    parameter int DATA_W  = 32,
    parameter int NREGS   = 32,
    parameter int ADDR_W  = 5,
    parameter int CID_W   = 3,
    parameter int CID_REG = 15,
    parameter int K1_REG  = 19,
    parameter int K1_VAL  = 1,
    parameter int K2_REG  = 20,
    parameter int K2_VAL  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CID_W-1:0]  core_id,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clr_req,
    output logic              busy
);

    localparam int IW = (NREGS > 1) ? $clog2(NREGS) : 1;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t            state, state_nx;
    logic [IW-1:0]     cnt, cnt_nx;
    logic [DATA_W-1:0] regs [NREGS];
    logic              wr_acc;
    logic              clr_we;

    // Index 0 and anything past the last register read as zero.
    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return (a != '0) && (32'(a) < 32'(NREGS));
    endfunction

    function automatic logic [DATA_W-1:0] preset(input logic [IW-1:0] i);
        if (i == IW'(K1_REG))
            return DATA_W'(K1_VAL);
        else if (i == IW'(K2_REG))
            return DATA_W'(K2_VAL);
        else
            return '0;
    endfunction

    function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] a);
        if (!in_range(a))
            return '0;
        else if (a == ADDR_W'(CID_REG))
            return DATA_W'(core_id);
        else if (wr_acc && (wr_addr == a))
            return wr_data;
        else
            return regs[a[IW-1:0]];
    endfunction

    assign busy     = (state == CLEAR);
    assign wr_ready = ~busy;

    // Writes to index 0, the core-ID slot or out of range are dropped,
    // which also keeps them off the bypass path.
    assign wr_acc = wr_en && wr_ready && in_range(wr_addr)
                    && (wr_addr != ADDR_W'(CID_REG));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // CID_REG still takes a clear cycle so the sequence length is fixed.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clr_we   = 1'b0;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nx = CLEAR;
                    cnt_nx   = IW'(1);
                end
            end
            CLEAR: begin
                clr_we = (cnt != IW'(CID_REG));
                if (cnt == IW'(NREGS - 1))
                    state_nx = IDLE;
                else
                    cnt_nx = cnt + IW'(1);
            end
            default: state_nx = IDLE;
        endcase
    end

    // Clear writes and port writes never coincide: wr_ready is low in CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++)
                regs[i] <= preset(IW'(i));
        end else if (clr_we) begin
            regs[cnt] <= preset(cnt);
        end else if (wr_acc) begin
            regs[wr_addr[IW-1:0]] <= wr_data;
        end
    end

    always_comb begin
        rd_data_a = rd_mux(rd_addr_a);
        rd_data_b = rd_mux(rd_addr_b);
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed self-checking bench for regfile_param.
// Uses a 6-bit address so out-of-range indices (e.g. 40) are reachable.
module tb_regfile_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  core_id;
    logic [5:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [5:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_ready;
    logic        clr_req;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    regfile_param #(
        .ADDR_W(6)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .core_id   (core_id),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_req   (clr_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd2(input logic [5:0] a, input logic [5:0] b);
        rd_addr_a = a;
        rd_addr_b = b;
        #1;
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    int  busy_cnt;
    int  stall_bad;
    logic wr_done;

    initial begin
        rst_n     = 1'b0;
        core_id   = 3'd3;
        rd_addr_a = '0;
        rd_addr_b = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_req   = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        rd2(6'd19, 6'd20);
        chk("rst_k1", rd_data_a, 32'd1);
        chk("rst_k2", rd_data_b, 32'd4);
        rd2(6'd7, 6'd0);
        chk("rst_r7", rd_data_a, 32'd0);
        chk("rst_r0", rd_data_b, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrdy", 32'(wr_ready), 32'd1);

        // Write with same-cycle bypass
        wr_en = 1'b1; wr_addr = 6'd5; wr_data = 32'hDEADBEEF;
        rd2(6'd5, 6'd6);
        chk("byp_a", rd_data_a, 32'hDEADBEEF);
        chk("byp_other", rd_data_b, 32'd0);
        next();
        wr_en = 1'b0; wr_data = '0;
        rd2(6'd5, 6'd5);
        chk("stored_a", rd_data_a, 32'hDEADBEEF);
        chk("stored_b", rd_data_b, 32'hDEADBEEF);

        // Protected addresses, bypass suppressed too
        wr_en = 1'b1; wr_data = 32'hFFFF_FFFF;
        wr_addr = 6'd0;  rd2(6'd0, 6'd1);
        chk("prot0_byp", rd_data_a, 32'd0);
        next();
        wr_addr = 6'd15; rd2(6'd15, 6'd1);
        chk("prot15_byp", rd_data_a, 32'd3);
        next();
        wr_addr = 6'd40; rd2(6'd40, 6'd8);
        chk("prot40_byp", rd_data_a, 32'd0);
        chk("prot40_r8", rd_data_b, 32'd0);
        next();
        wr_en = 1'b0;
        rd2(6'd0, 6'd15);
        chk("prot_r0", rd_data_a, 32'd0);
        chk("prot_r15", rd_data_b, 32'd3);
        rd2(6'd40, 6'd8);
        chk("prot_r40", rd_data_a, 32'd0);
        chk("prot_r8", rd_data_b, 32'd0);
        rd2(6'd1, 6'd5);
        chk("prot_r1", rd_data_a, 32'd0);
        chk("prot_r5", rd_data_b, 32'hDEADBEEF);
        rd2(6'd31, 6'd19);
        chk("prot_r31", rd_data_a, 32'd0);
        chk("prot_r19", rd_data_b, 32'd1);

        // Fill 1..31 with 0xA5
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = 6'(i); wr_data = 32'hA5;
            next();
        end
        wr_en = 1'b0;
        rd2(6'd9, 6'd19);
        chk("fill_r9", rd_data_a, 32'hA5);
        chk("fill_r19", rd_data_b, 32'hA5);
        rd2(6'd31, 6'd15);
        chk("fill_r31", rd_data_a, 32'hA5);
        chk("fill_r15", rd_data_b, 32'd3);

        // Clear with a stalled write to reg 3 and an ignored clr_req
        clr_req = 1'b1;
        next();
        clr_req = 1'b0;
        busy_cnt = 0; stall_bad = 0; wr_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (i == 2) begin
                wr_en = 1'b1; wr_addr = 6'd3; wr_data = 32'h77;
            end
            clr_req = (i == 10);
            rd2(6'd3, 6'd9);
            if (i == 5) begin
                chk("mid_r3", rd_data_a, 32'd0);
                chk("mid_r9", rd_data_b, 32'hA5);
            end
            if (busy) begin
                busy_cnt++;
                if (wr_ready) stall_bad++;
            end
            if (!busy && wr_en && i > 2) begin
                chk("stall_acc_rdy", 32'(wr_ready), 32'd1);
                wr_done = 1'b1;
            end
            next();
            if (wr_done) wr_en = 1'b0;
        end
        clr_req = 1'b0;
        chk("clr_busy_len", 32'(busy_cnt), 32'd31);
        chk("clr_stall", 32'(stall_bad), 32'd0);
        chk("clr_wr_done", 32'(wr_done), 32'd1);
        rd2(6'd9, 6'd19);
        chk("clr_r9", rd_data_a, 32'd0);
        chk("clr_r19", rd_data_b, 32'd1);
        rd2(6'd20, 6'd3);
        chk("clr_r20", rd_data_a, 32'd4);
        chk("clr_r3", rd_data_b, 32'h77);
        rd2(6'd31, 6'd15);
        chk("clr_r31", rd_data_a, 32'd0);
        chk("clr_r15", rd_data_b, 32'd3);

        // Prepare non-preset contents, then clr_req with a write
        wr_en = 1'b1; wr_addr = 6'd19; wr_data = 32'hAA; next();
        wr_addr = 6'd25; wr_data = 32'hBB; next();
        wr_addr = 6'd2; wr_data = 32'h12; clr_req = 1'b1;
        rd2(6'd2, 6'd25);
        chk("simul_rdy", 32'(wr_ready), 32'd1);
        chk("simul_byp", rd_data_a, 32'h12);
        chk("simul_r25", rd_data_b, 32'hBB);
        next();
        wr_en = 1'b0; clr_req = 1'b0;
        rd2(6'd2, 6'd19);
        chk("simul_busy", 32'(busy), 32'd1);
        chk("simul_r2", rd_data_a, 32'h12);
        chk("simul_r19", rd_data_b, 32'hAA);

        // Abort when cnt reaches 10
        repeat (9) next();
        rd2(6'd5, 6'd25);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        chk("abort_pre_r5", rd_data_a, 32'd0);
        chk("abort_pre_r25", rd_data_b, 32'hBB);
        rst_n = 1'b0;
        rd2(6'd19, 6'd20);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_wrdy", 32'(wr_ready), 32'd1);
        chk("abort_r19", rd_data_a, 32'd1);
        chk("abort_r20", rd_data_b, 32'd4);
        rd2(6'd25, 6'd3);
        chk("abort_r25", rd_data_a, 32'd0);
        chk("abort_r3", rd_data_b, 32'd0);
        next();
        rst_n = 1'b1;
        next();
        rd2(6'd19, 6'd25);
        chk("post_busy", 32'(busy), 32'd0);
        chk("post_r19", rd_data_a, 32'd1);
        chk("post_r25", rd_data_b, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
